// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- sequencing wrapper around an external 4-bit combinational ALU.
//
// It takes one command at a time and runs it through three states:
//   IDLE : ready for a command; an accepted command registers the ALU operands.
//   EXEC : the ALU inputs are stable, so alu_y is captured at the end of this cycle.
//   RESP : the result is offered until the consumer accepts it.
// A command is accepted at edge N and res_valid rises two cycles later. Commands
// never overlap.
//
// Ports:
//   clk, rst_n        rising-edge clock; asynchronous active-low reset
//   cmd_valid/ready   command handshake (cmd_ready is 1 only in IDLE, out of reset)
//   cmd_op            ALU select: 00 ~A, 01 A+B, 10 A-B, 11 2A
//   cmd_use_acc       1 = take the A operand from the accumulator
//   cmd_a, cmd_b      command operands
//   alu_a/b/s         registered drive to the external ALU
//   alu_y             combinational result from the external ALU
//   res_valid/ready   result handshake
//   res_data/zero     captured result and its zero flag
//   acc               accumulator (the last captured result)
//   op_count          number of handshaken results, saturating
module alu_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_use_acc,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_s,
   input  logic [WIDTH-1:0] alu_y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_reg,    state_next;
   logic [WIDTH-1:0] alu_a_reg,    alu_a_next;
   logic [WIDTH-1:0] alu_b_reg,    alu_b_next;
   logic [1:0]       alu_s_reg,    alu_s_next;
   logic [WIDTH-1:0] res_data_reg, res_data_next;
   logic             res_zero_reg, res_zero_next;
   logic [WIDTH-1:0] acc_reg,      acc_next;
   logic [CNT_W-1:0] op_count_reg, op_count_next;

   // The state register resets to IDLE, so cmd_ready is also gated with rst_n
   // to keep it low for as long as reset is held.
   assign cmd_ready = rst_n && (state_reg == IDLE);
   assign res_valid = (state_reg == RESP);

   assign alu_a    = alu_a_reg;
   assign alu_b    = alu_b_reg;
   assign alu_s    = alu_s_reg;
   assign res_data = res_data_reg;
   assign res_zero = res_zero_reg;
   assign acc      = acc_reg;
   assign op_count = op_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         alu_a_reg    <= '0;
         alu_b_reg    <= '0;
         alu_s_reg    <= '0;
         res_data_reg <= '0;
         res_zero_reg <= 1'b0;
         acc_reg      <= '0;
         op_count_reg <= '0;
      end else begin
         state_reg    <= state_next;
         alu_a_reg    <= alu_a_next;
         alu_b_reg    <= alu_b_next;
         alu_s_reg    <= alu_s_next;
         res_data_reg <= res_data_next;
         res_zero_reg <= res_zero_next;
         acc_reg      <= acc_next;
         op_count_reg <= op_count_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      alu_a_next    = alu_a_reg;
      alu_b_next    = alu_b_reg;
      alu_s_next    = alu_s_reg;
      res_data_next = res_data_reg;
      res_zero_next = res_zero_reg;
      acc_next      = acc_reg;
      op_count_next = op_count_reg;

      case (state_reg)
         IDLE: begin
            // In IDLE, cmd_ready is 1 whenever the clock is running out of reset.
            if (cmd_valid) begin
               // acc here is the last completed result (0 after reset).
               alu_a_next = cmd_use_acc ? acc_reg : cmd_a;
               alu_b_next = cmd_b;
               alu_s_next = cmd_op;
               state_next = EXEC;
            end
         end
         EXEC: begin
            // The operands were registered at the previous edge, so alu_y has
            // a full cycle to settle before it is captured here.
            res_data_next = alu_y;
            acc_next      = alu_y;
            res_zero_next = (alu_y == '0);
            state_next    = RESP;
         end
         RESP: begin
            if (res_ready) begin
               if (op_count_reg != CNT_MAX) begin
                  op_count_next = op_count_reg + CNT_ONE;
               end
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl. Two instances share one stimulus stream: dut uses
// the default 8-bit counter, dut2 uses a 2-bit counter to show saturation.
// The external ALU is modelled in the bench. A transaction-level model tracks
// what every output must be; a compare process checks both instances on every
// falling edge, and directed tests add hand-computed literal expectations.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic       cmd_use_acc = 1'b0;
   logic [3:0] cmd_a = 4'd0;
   logic [3:0] cmd_b = 4'd0;
   logic       res_ready = 1'b0;

   logic       cmd_ready, res_valid, res_zero;
   logic [3:0] alu_a, alu_b, alu_y, res_data, acc;
   logic [1:0] alu_s;
   logic [7:0] op_count;

   logic       cmd_ready2, res_valid2, res_zero2;
   logic [3:0] alu_a2, alu_b2, alu_y2, res_data2, acc2;
   logic [1:0] alu_s2;
   logic [1:0] op_count2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // What the ALU computes, written as plain modulo-16 arithmetic.
   function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
      int r;
      case (s)
         2'd0:    r = 15 - int'(a);
         2'd1:    r = int'(a) + int'(b);
         2'd2:    r = int'(a) - int'(b) + 16;
         default: r = 2 * int'(a);
      endcase
      return 4'(r % 16);
   endfunction

   assign alu_y  = alu_fn(alu_a, alu_b, alu_s);
   assign alu_y2 = alu_fn(alu_a2, alu_b2, alu_s2);

   alu_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_use_acc(cmd_use_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .acc(acc), .op_count(op_count)
   );

   alu_seq_ctrl #(.WIDTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
      .cmd_use_acc(cmd_use_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_y(alu_y2),
      .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
      .res_zero(res_zero2), .acc(acc2), .op_count(op_count2)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // m_busy: a command is in flight; m_age: 0 while its result is being
   // computed, 1 once the result is on offer.
   bit       m_busy = 0;
   int       m_age = 0;
   logic [3:0] m_a = 0, m_b = 0, m_acc = 0, m_res = 0;
   logic [1:0] m_s = 0;
   bit       m_zero = 0;
   int       m_cnt = 0, m_cnt2 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_age = 0; m_a = 0; m_b = 0; m_s = 0;
         m_acc = 0; m_res = 0; m_zero = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_a    = cmd_use_acc ? m_acc : cmd_a;
            m_b    = cmd_b;
            m_s    = cmd_op;
            m_busy = 1;
            m_age  = 0;
         end
      end else if (m_age == 0) begin
         m_res  = alu_fn(m_a, m_b, m_s);
         m_acc  = m_res;
         m_zero = (m_res == 4'd0);
         m_age  = 1;
      end else if (res_ready) begin
         m_busy = 0;
         if (m_cnt < 255) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
         $display("txn: s=%0d a=%h b=%h -> y=%h count=%0d", m_s, m_a, m_b, m_res, m_cnt);
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      check("cmd_ready", cmd_ready, int'(rst_n && !m_busy));
      check("res_valid", res_valid, int'(m_busy && m_age == 1));
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_s", alu_s, m_s);
      check("res_data", res_data, m_res);
      check("res_zero", res_zero, m_zero);
      check("acc", acc, m_acc);
      check("op_count", op_count, m_cnt);
      check("dut2.cmd_ready", cmd_ready2, int'(rst_n && !m_busy));
      check("dut2.res_valid", res_valid2, int'(m_busy && m_age == 1));
      check("dut2.res_data", res_data2, m_res);
      check("dut2.op_count", op_count2, m_cnt2);
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [1:0] op, input logic ua, input logic [3:0] a,
                       input logic [3:0] b);
      check("send.cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_use_acc = ua; cmd_a = a; cmd_b = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // One command with res_ready held high; checks the exact 2-cycle latency.
   task automatic do_op(input string tag, input logic [1:0] op, input logic ua,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_a, input logic [3:0] exp_y);
      send(op, ua, a, b);
      @(negedge clk);
      check({tag, ".alu_a"}, alu_a, exp_a);
      check({tag, ".alu_b"}, alu_b, b);
      check({tag, ".alu_s"}, alu_s, op);
      check({tag, ".exec_valid"}, res_valid, 0);
      @(negedge clk);
      check({tag, ".res_valid"}, res_valid, 1);
      check({tag, ".res_data"}, res_data, exp_y);
      check({tag, ".acc"}, acc, exp_y);
      check({tag, ".res_zero"}, res_zero, int'(exp_y == 4'd0));
      @(negedge clk);
      check({tag, ".done_valid"}, res_valid, 0);
      check({tag, ".idle_ready"}, cmd_ready, 1);
   endtask

   initial begin
      logic [1:0] sat_exp [5];
      logic [3:0] t2_y [4];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      t2_y    = '{4'h6, 4'hC, 4'h6, 4'h2};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.cmd_ready", cmd_ready, 0);
      check("rst.res_valid", res_valid, 0);
      check("rst.op_count", op_count, 0);
      check("rst.acc", acc, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);

      // 5 + 3 = 8
      do_op("t1", 2'b01, 1'b0, 4'd5, 4'd3, 4'd5, 4'd8);
      check("t1.op_count", op_count, 1);
      check("t6.count0", op_count2, sat_exp[0]);

      // All four ops on 9, 3
      for (int i = 0; i < 4; i++) begin
         do_op("t2", 2'(i), 1'b0, 4'h9, 4'h3, 4'h9, t2_y[i]);
         check("t6.count", op_count2, sat_exp[i+1]);
      end
      check("t2.op_count", op_count, 5);

      // Chaining through the accumulator: 7+1 = 8, then 8-8 = 0
      do_op("t3a", 2'b01, 1'b0, 4'd7, 4'd1, 4'd7, 4'd8);
      do_op("t3b", 2'b10, 1'b1, 4'd3, 4'd8, 4'd8, 4'd0);
      check("t3.op_count", op_count, 7);

      // Backpressure: 2 + 3 = 5 held for 5 cycles, ignored command pulses
      res_ready = 1'b0;
      send(2'b01, 1'b0, 4'd2, 4'd3);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 4'hF; cmd_b = 4'hF;
         @(negedge clk);
         check("t4.res_valid", res_valid, 1);
         check("t4.res_data", res_data, 5);
         check("t4.cmd_ready", cmd_ready, 0);
         check("t4.alu_a", alu_a, 2);
         check("t4.alu_s", alu_s, 1);
         cmd_valid = 1'b0;
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      check("t4.op_count", op_count, 8);
      check("t4.res_valid_after", res_valid, 0);
      check("t4.cmd_ready_after", cmd_ready, 1);
      res_ready = 1'b1;

      // Reset in EXEC aborts the operation
      send(2'b01, 1'b0, 4'd1, 4'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5.res_valid", res_valid, 0);
      check("t5.acc", acc, 0);
      check("t5.alu_a", alu_a, 0);
      check("t5.alu_b", alu_b, 0);
      check("t5.alu_s", alu_s, 0);
      check("t5.cmd_ready", cmd_ready, 0);
      check("t5.op_count", op_count, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("t5.cmd_ready_rel", cmd_ready, 1);
      check("t5.op_count_rel", op_count, 0);

      // Accumulator after reset is 0: 0 + 4 = 4
      do_op("t5b", 2'b01, 1'b1, 4'd9, 4'd4, 4'd0, 4'd4);
      check("t5b.op_count", op_count, 1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing wrapper around the 4-bit combinational ALU.
- Accepts one command at a time over a valid/ready interface.
- Registers the operands and drives them onto the ALU's A/B/S inputs.
- Captures the ALU result into an accumulator and returns it over a valid/ready result interface.
- Sits directly upstream and downstream of the ALU; the ALU instance lives outside this block in the same parent.

Parameters:
WIDTH, 4, datapath width; must match ALU width.
CNT_W, 8, width of completed-operation counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_op  input  2  ALU select: 00 = ~A, 01 = A+B, 10 = A-B, 11 = 2A.
cmd_use_acc  input  1  1 = use accumulator as A operand; 0 = use cmd_a.
cmd_a  input  WIDTH  A operand.
cmd_b  input  WIDTH  B operand.
alu_a  output  WIDTH  to ALU A.
alu_b  output  WIDTH  to ALU B.
alu_s  output  2  to ALU S.
alu_y  input  WIDTH  from ALU Y (combinational).
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_data  output  WIDTH  result value.
res_zero  output  1  res_data == 0.
acc  output  WIDTH  current accumulator value.
op_count  output  CNT_W  completed (handshaken) results, saturating.

Behaviour:
Reset (async, rst_n=0):
- State = IDLE.
- alu_a, alu_b, alu_s, res_data, acc and op_count all = 0.
- res_valid = 0, res_zero = 0.
- cmd_ready = 0 while rst_n is low.
- Deassertion is used synchronously (2-flop sync is not required in this block).

FSM states: IDLE, EXEC, RESP.

IDLE:
- cmd_ready = 1.
- On cmd_valid & cmd_ready at edge N:
  - alu_a <= (cmd_use_acc ? acc : cmd_a).
  - alu_b <= cmd_b.
  - alu_s <= cmd_op.
  - Next state = EXEC.
- Without cmd_valid: stay in IDLE; all regs hold.

EXEC (cycle N+1):
- cmd_ready = 0.
- ALU inputs are registered and stable, so alu_y settles within the cycle.
- At edge N+1: res_data <= alu_y, acc <= alu_y, res_zero <= (alu_y == 0). Next state = RESP.

RESP (from cycle N+2):
- res_valid = 1 and cmd_ready = 0.
- res_data, res_zero and acc hold until res_ready.
- On res_valid & res_ready: res_valid <= 0, op_count increments (saturates at all-ones), next state = IDLE.

Latency and throughput:
- Command accept to res_valid is 2 cycles.
- Minimum command-to-command spacing is 3 cycles with res_ready held high. No overlap.

Hold and drive rules:
- alu_a, alu_b and alu_s hold their last values in IDLE and RESP. They change only on command accept.
- cmd_* inputs are ignored whenever cmd_ready = 0.

Arithmetic:
- All results are modulo 2^WIDTH. No carry or overflow output.
- The subtract wraps: 3-5 = 4'hE.

Boundary conditions:
- cmd_use_acc=1 reads acc as it is at the accept edge, i.e. the last completed result. After reset that value is 0.
- res_ready may be high before res_valid. The result still stays valid for at least one cycle (the RESP cycle).
- op_count at 2^CNT_W-1 stays put on further completions.
- Reset asserted in EXEC or RESP aborts the operation immediately. The result is lost, acc = 0 and op_count is not incremented.

Test Plan:
1. Reset, then cmd op=01, a=5, b=3, use_acc=0, res_ready=1 → alu_a=5, alu_b=3, alu_s=01 in the cycle after accept; res_valid two cycles after accept with res_data=8, acc=8, res_zero=0, op_count=1.
2. The four ops in sequence, each with a=4'h9, b=4'h3 and use_acc=0 → 00 gives 4'h6; 01 gives 4'hC; 10 gives 4'h6; 11 gives 4'h2 (wrap).
3. Chaining: op=01 a=7 b=1 (result 8), then op=10 use_acc=1 b=8 → alu_a=8 and result 0 with res_zero=1, acc=0.
4. Backpressure: res_ready=0 for 5 cycles after res_valid → res_valid and res_data stay stable; cmd_ready=0 throughout; cmd_valid pulses are ignored (alu_* unchanged); a single res_ready pulse returns the block to IDLE and op_count increments once.
5. Reset mid-op: assert rst_n=0 in EXEC → res_valid=0, acc=0, alu_*=0 asynchronously; after release cmd_ready=1 and op_count=0.
6. CNT_W=2: complete 5 operations → op_count reads 1, 2, 3, 3, 3.
